// File: rtl/alu_packet_engine.sv
// alu_packet_engine
//    Byte-stream packet engine sitting between a UART receiver and transmitter.
//    Parses a 4-byte header (opcode, reserved, LEN lo, LEN hi; LEN counts the
//    whole packet) and then either echoes the payload straight through (ECHO),
//    or folds 32-bit little-endian payload words with 32-bit add (ADD32) or
//    32-bit multiply (MUL32) and returns the 4-byte little-endian result.
//    Malformed or unknown packets raise a one-cycle error_o pulse and their
//    payload is drained silently.
//
// Ports
//    clk            system clock
//    rst            synchronous active-high reset
//    s_axis_tdata   received byte          s_axis_tvalid  received byte valid
//    s_axis_tready  engine accepts byte
//    m_axis_tdata   byte to transmitter    m_axis_tvalid  output byte valid
//    m_axis_tready  transmitter accepts byte
//    busy_o         high whenever the engine is not idle
//    error_o        one-cycle pulse when a packet is rejected
module alu_packet_engine (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       busy_o,
   output logic       error_o
);

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam logic [7:0] OP_MUL  = 8'h88;

   typedef enum logic [3:0] {
      ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_ECHO,
      ST_OPERAND, ST_COMPUTE, ST_RESULT, ST_DRAIN
   } state_t;

   state_t      state_q;
   logic [7:0]  opcode_q;
   logic [7:0]  len_lo_q;
   logic [15:0] cnt_q;        // payload bytes still to be received
   logic [1:0]  byte_idx_q;   // byte position within the operand word
   logic        first_q;      // next completed word seeds the accumulator
   logic [31:0] word_q;       // operand word under assembly
   logic [31:0] opw_q;        // operand for COMPUTE; multiplier during MUL32
   logic [31:0] acc_q;
   logic [31:0] mcand_q;      // shifted multiplicand during MUL32
   logic [31:0] prod_q;       // partial product during MUL32
   logic [4:0]  mcnt_q;
   logic [7:0]  out_data_q;
   logic        out_valid_q;
   logic [1:0]  out_idx_q;
   logic        err_q;

   logic        rx_state;
   logic        s_fire;
   logic [15:0] len_w;
   logic [15:0] payload_w;
   logic [31:0] word_w;
   logic [31:0] mul_step_w;
   logic [31:0] add_w;
   logic [31:0] result_w;
   logic        is_mul;
   logic        compute_done;
   logic [1:0]  out_idx_nxt;

   assign rx_state = (state_q == ST_IDLE)    || (state_q == ST_RSVD)  ||
                     (state_q == ST_LEN_LO)  || (state_q == ST_LEN_HI) ||
                     (state_q == ST_OPERAND) || (state_q == ST_DRAIN);

   // ECHO is a zero-latency pass-through, so the handshake is combinational there.
   assign s_axis_tready = !rst && (rx_state || ((state_q == ST_ECHO) && m_axis_tready));
   assign m_axis_tvalid = !rst && ((state_q == ST_ECHO) ? s_axis_tvalid : out_valid_q);
   assign m_axis_tdata  = rst ? '0 : ((state_q == ST_ECHO) ? s_axis_tdata : out_data_q);
   assign busy_o        = (state_q != ST_IDLE);
   assign error_o       = err_q;

   assign s_fire       = s_axis_tvalid && s_axis_tready;
   assign len_w        = {s_axis_tdata, len_lo_q};
   assign payload_w    = len_w - 16'd4;
   assign word_w       = {s_axis_tdata, word_q[23:0]};
   assign is_mul       = (opcode_q == OP_MUL);
   // One shift-add step: bit 0 of the (right-shifting) multiplier gates the
   // (left-shifting) multiplicand into the partial product.
   assign mul_step_w   = prod_q + (opw_q[0] ? mcand_q : '0);
   assign add_w        = acc_q + opw_q;
   assign result_w     = is_mul ? mul_step_w : add_w;
   assign compute_done = !is_mul || (mcnt_q == 5'd31);
   assign out_idx_nxt  = out_idx_q + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         opcode_q    <= '0;
         len_lo_q    <= '0;
         cnt_q       <= '0;
         byte_idx_q  <= '0;
         first_q     <= 1'b0;
         word_q      <= '0;
         opw_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         prod_q      <= '0;
         mcnt_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s_fire) begin
                  opcode_q <= s_axis_tdata;
                  state_q  <= ST_RSVD;
               end
            end
            ST_RSVD: begin
               if (s_fire) state_q <= ST_LEN_LO;
            end
            ST_LEN_LO: begin
               if (s_fire) begin
                  len_lo_q <= s_axis_tdata;
                  state_q  <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (s_fire) begin
                  cnt_q      <= (len_w < 16'd4) ? '0 : payload_w;
                  byte_idx_q <= '0;
                  first_q    <= 1'b1;
                  if (len_w < 16'd4) begin
                     err_q   <= 1'b1;
                     state_q <= ST_IDLE;
                  end else if (opcode_q == OP_ECHO) begin
                     state_q <= (payload_w == '0) ? ST_IDLE : ST_ECHO;
                  end else if ((opcode_q == OP_ADD) || (opcode_q == OP_MUL)) begin
                     if (payload_w == '0) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                     end else if ((payload_w[1:0] != 2'b00) || (payload_w < 16'd8)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DRAIN;
                     end else begin
                        state_q <= ST_OPERAND;
                     end
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= (payload_w == '0) ? ST_IDLE : ST_DRAIN;
                  end
               end
            end
            ST_ECHO, ST_DRAIN: begin
               if (s_fire) begin
                  cnt_q <= cnt_q - 16'd1;
                  if (cnt_q == 16'd1) state_q <= ST_IDLE;
               end
            end
            ST_OPERAND: begin
               if (s_fire) begin
                  cnt_q                         <= cnt_q - 16'd1;
                  word_q[{byte_idx_q, 3'b000} +: 8] <= s_axis_tdata;
                  byte_idx_q                    <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     if (first_q) begin
                        acc_q   <= word_w;
                        first_q <= 1'b0;
                     end else begin
                        opw_q   <= word_w;
                        mcand_q <= acc_q;
                        prod_q  <= '0;
                        mcnt_q  <= '0;
                        state_q <= ST_COMPUTE;
                     end
                  end
               end
            end
            ST_COMPUTE: begin
               if (is_mul) begin
                  prod_q  <= mul_step_w;
                  mcand_q <= mcand_q << 1;
                  opw_q   <= opw_q >> 1;
                  mcnt_q  <= mcnt_q + 5'd1;
               end
               if (compute_done) begin
                  acc_q <= result_w;
                  if (cnt_q == '0) begin
                     out_data_q  <= result_w[7:0];
                     out_valid_q <= 1'b1;
                     out_idx_q   <= '0;
                     state_q     <= ST_RESULT;
                  end else begin
                     state_q <= ST_OPERAND;
                  end
               end
            end
            ST_RESULT: begin
               if (m_axis_tready) begin
                  if (out_idx_q == 2'd3) begin
                     out_valid_q <= 1'b0;
                     state_q     <= ST_IDLE;
                  end else begin
                     out_idx_q  <= out_idx_nxt;
                     out_data_q <= acc_q[{out_idx_nxt, 3'b000} +: 8];
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Directed bench for alu_packet_engine: a table of whole packets with their
// expected output bytes and error-pulse counts, plus hand-written sequences
// for MUL32 timing, output back-pressure and reset during COMPUTE.
module tb_alu_packet_engine;

   logic       clk;
   logic       rst;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       busy_o;
   logic       error_o;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [7:0]  outq[$];
   int unsigned err_seen = 0;

   typedef struct {
      int unsigned  nin;
      logic [159:0] din;   // byte i at [8*(nin-1-i) +: 8]
      int unsigned  nout;
      logic [31:0]  dout;  // byte j at [8*(nout-1-j) +: 8]
      int unsigned  nerr;
      int unsigned  gap;
   } vec_t;

   vec_t vq[$];

   alu_packet_engine dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy_o        (busy_o),
      .error_o       (error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change #1 after posedge, so values seen at negedge are what the
   // next posedge will transfer.
   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) outq.push_back(m_axis_tdata);
      if (error_o) err_seen++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic addv(input int unsigned n, input logic [159:0] d, input int unsigned no,
                       input logic [31:0] o, input int unsigned ne, input int unsigned gap);
      vec_t v;
      v.nin = n; v.din = d; v.nout = no; v.dout = o; v.nerr = ne; v.gap = gap;
      vq.push_back(v);
   endtask

   task automatic send_pkt(input int unsigned n, input logic [159:0] d, input int unsigned gap);
      for (int unsigned i = 0; i < n; i++) begin
         int unsigned tries;
         bit          acc;
         tries = 0;
         acc   = 1'b0;
         s_axis_tdata  = d[8*(n-1-i) +: 8];
         s_axis_tvalid = 1'b1;
         while (!acc && tries < 200) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk); #1;
            tries++;
         end
         s_axis_tvalid = 1'b0;
         if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0d tready stayed 0, expected 1", i);
            return;
         end
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_idle(input string tag);
      int unsigned k;
      bit          done;
      k    = 0;
      done = 1'b0;
      while (!done && k < 300) begin
         @(negedge clk);
         if (!busy_o && !m_axis_tvalid) done = 1'b1;
         @(posedge clk); #1;
         k++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_idle_timeout: busy_o=%0b, expected 0", tag, busy_o);
      end
   endtask

   initial begin
      int unsigned base;
      int unsigned ebase;
      int unsigned got;
      int unsigned ncyc;
      bit          done;
      bit          stalled;
      logic [7:0]  held;

      rst           = 1'b1;
      s_axis_tdata  = 8'h00;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;

      // Reset state, with tvalid asserted to show tready is held low.
      repeat (3) @(posedge clk);
      #1 s_axis_tvalid = 1'b1;
      s_axis_tdata = 8'hEC;
      @(negedge clk);
      chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
      chk("rst_busy",     32'(busy_o),        32'd0);
      chk("rst_error",    32'(error_o),       32'd0);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_s_tready", 32'(s_axis_tready), 32'd1);
      @(posedge clk); #1;

      // ECHO with input stalls between bytes
      addv(7,  160'({8'hEC,8'h00,8'h07,8'h00,8'h41,8'h42,8'h43}), 3, 32'h00414243, 0, 2);
      // ADD32 wrap
      addv(12, 160'({8'hAD,8'h00,8'h0C,8'h00,8'h01,8'h00,8'h00,8'h00,8'hFF,8'hFF,8'hFF,8'hFF}),
           4, 32'h00000000, 0, 0);
      // MUL32 3*5*7 = 105
      addv(16, 160'({8'h88,8'h00,8'h10,8'h00,8'h03,8'h00,8'h00,8'h00,8'h05,8'h00,8'h00,8'h00,
                     8'h07,8'h00,8'h00,8'h00}), 4, 32'h69000000, 0, 0);
      // unknown opcode, 2 bytes drained, then ECHO 5A
      addv(6,  160'({8'h55,8'h00,8'h06,8'h00,8'hAA,8'hBB}), 0, 32'h0, 1, 0);
      addv(5,  160'({8'hEC,8'h00,8'h05,8'h00,8'h5A}), 1, 32'h0000005A, 0, 0);
      // ADD32 payload 5 (not multiple of 4) drained
      addv(9,  160'({8'hAD,8'h00,8'h09,8'h00,8'h11,8'h22,8'h33,8'h44,8'h55}), 0, 32'h0, 1, 0);
      // LEN < 4
      addv(4,  160'({8'hEC,8'h00,8'h03,8'h00}), 0, 32'h0, 1, 0);
      // ECHO empty payload: silent
      addv(4,  160'({8'hEC,8'h00,8'h04,8'h00}), 0, 32'h0, 0, 0);
      // ADD32 empty payload
      addv(4,  160'({8'hAD,8'h00,8'h04,8'h00}), 0, 32'h0, 1, 0);
      // ADD32 single word (payload < 8) drained
      addv(8,  160'({8'hAD,8'h00,8'h08,8'h00,8'h01,8'h02,8'h03,8'h04}), 0, 32'h0, 1, 0);
      // unknown opcode, empty payload
      addv(4,  160'({8'h12,8'h00,8'h04,8'h00}), 0, 32'h0, 1, 0);
      // ADD32 three words: 12345678+11111111+01010101 = 2446688A
      addv(16, 160'({8'hAD,8'h00,8'h10,8'h00,8'h78,8'h56,8'h34,8'h12,8'h11,8'h11,8'h11,8'h11,
                     8'h01,8'h01,8'h01,8'h01}), 4, 32'h8A684624, 0, 0);
      // MUL32 12345678*10 = 23456780
      addv(12, 160'({8'h88,8'h00,8'h0C,8'h00,8'h78,8'h56,8'h34,8'h12,8'h10,8'h00,8'h00,8'h00}),
           4, 32'h80674523, 0, 0);
      // MUL32 FFFFFFFF*FFFFFFFF mod 2^32 = 1
      addv(12, 160'({8'h88,8'h00,8'h0C,8'h00,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF}),
           4, 32'h01000000, 0, 0);
      // two ECHO packets back to back, second opcode right after return to IDLE
      addv(10, 160'({8'hEC,8'h00,8'h05,8'h00,8'h5A,8'hEC,8'h00,8'h05,8'h00,8'h5B}),
           2, 32'h00005A5B, 0, 0);

      for (int unsigned v = 0; v < vq.size(); v++) begin
         base  = outq.size();
         ebase = err_seen;
         send_pkt(vq[v].nin, vq[v].din, vq[v].gap);
         wait_idle($sformatf("vec%0d", v));
         got = outq.size() - base;
         chk($sformatf("vec%0d_nbytes", v), got, vq[v].nout);
         for (int unsigned j = 0; j < vq[v].nout && j < got; j++)
            chk($sformatf("vec%0d_byte%0d", v, j), 32'(outq[base+j]),
                32'(vq[v].dout[8*(vq[v].nout-1-j) +: 8]));
         chk($sformatf("vec%0d_errors", v), err_seen - ebase, vq[v].nerr);
      end

      // MUL32 COMPUTE lasts exactly 32 cycles with tready low
      base = outq.size();
      send_pkt(12, 160'({8'h88,8'h00,8'h0C,8'h00,8'h03,8'h00,8'h00,8'h00,8'h05,8'h00,8'h00,8'h00}), 0);
      ncyc = 0;
      done = 1'b0;
      for (int unsigned k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (m_axis_tvalid) done = 1'b1;
         else if (!s_axis_tready && busy_o) ncyc++;
      end
      chk("mul_compute_cycles", ncyc, 32'd32);
      @(posedge clk); #1;
      wait_idle("mul_timing");
      chk("mul_timing_nbytes", outq.size() - base, 32'd4);
      if (outq.size() - base == 4) begin
         chk("mul_timing_b0", 32'(outq[base]),   32'h0F);
         chk("mul_timing_b3", 32'(outq[base+3]), 32'h00);
      end

      // Back-pressure: 01020304+10203040 = 11223344, tready toggling
      base = outq.size();
      send_pkt(12, 160'({8'hAD,8'h00,8'h0C,8'h00,8'h04,8'h03,8'h02,8'h01,8'h40,8'h30,8'h20,8'h10}), 0);
      stalled = 1'b0;
      held    = 8'h00;
      done    = 1'b0;
      for (int unsigned k = 0; k < 60 && !done; k++) begin
         @(posedge clk); #1;
         m_axis_tready = ~m_axis_tready;
         @(negedge clk);
         if (stalled) begin
            chk("bp_valid_hold", 32'(m_axis_tvalid), 32'd1);
            chk("bp_data_hold",  32'(m_axis_tdata),  32'(held));
         end
         stalled = m_axis_tvalid && !m_axis_tready;
         held    = m_axis_tdata;
         if (!busy_o) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL bp_timeout: busy_o=%0b, expected 0", busy_o);
      end
      @(posedge clk); #1;
      m_axis_tready = 1'b1;
      chk("bp_nbytes", outq.size() - base, 32'd4);
      if (outq.size() - base == 4) begin
         chk("bp_b0", 32'(outq[base]),   32'h44);
         chk("bp_b1", 32'(outq[base+1]), 32'h33);
         chk("bp_b2", 32'(outq[base+2]), 32'h22);
         chk("bp_b3", 32'(outq[base+3]), 32'h11);
      end

      // Reset in the middle of a MUL32 COMPUTE
      base = outq.size();
      send_pkt(12, 160'({8'h88,8'h00,8'h0C,8'h00,8'h03,8'h00,8'h00,8'h00,8'h05,8'h00,8'h00,8'h00}), 0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_busy",     32'(busy_o),        32'd0);
      chk("midrst_s_tready", 32'(s_axis_tready), 32'd0);
      chk("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      send_pkt(5, 160'({8'hEC,8'h00,8'h05,8'h00,8'h33}), 0);
      wait_idle("midrst");
      repeat (40) begin @(posedge clk); #1; end
      chk("midrst_nbytes", outq.size() - base, 32'd1);
      if (outq.size() - base == 1) chk("midrst_b0", 32'(outq[base]), 32'h33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
